// File: rtl/bus_arbiter_pkg.sv
// Shared bus types for the two-master arbiter and the CPU/DMA adaptor blocks.
package bus_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_CPU,
    GRANT_DMA,
    RELEASE_CPU,
    RELEASE_DMA
  } arb_state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] address;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_arb_select.sv
// Priority selector: the CPU wins unless the DMA has been starved up to the limit.
module arb_select
  import bus_arbiter_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = 8'd8
) (
  input  logic             cpu_request,
  input  logic             dma_request,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_cpu,
  output logic             grant_dma
);

  always_comb begin
    grant_dma = dma_request && (!cpu_request || (starve_cnt == LIMIT));
    grant_cpu = cpu_request && !grant_dma;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master single-slave bus arbiter with a fixed-priority CPU and a starvation
// guard for the DMA. Every output comes straight from a flop.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_request,
  input  logic        i_cpu_rw,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  input  logic        i_dma_request,
  input  logic        i_dma_rw,
  input  logic [31:0] i_dma_address,
  input  logic [31:0] i_dma_wdata,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_ready,
  output logic        o_dma_stall,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  bus_req_t         bus_q, bus_d;
  logic             bus_request_q, bus_request_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             dma_ready_q, dma_ready_d;
  logic             dma_stall_q, dma_stall_d;

  bus_req_t cpu_req, dma_req;
  logic     grant_cpu, grant_dma;

  assign cpu_req = '{rw: i_cpu_rw, address: i_cpu_address, wdata: i_cpu_wdata};
  assign dma_req = '{rw: i_dma_rw, address: i_dma_address, wdata: i_dma_wdata};

  arb_select #(
    .LIMIT(LIMIT)
  ) u_select (
    .cpu_request(i_cpu_request),
    .dma_request(i_dma_request),
    .starve_cnt (starve_cnt_q),
    .grant_cpu  (grant_cpu),
    .grant_dma  (grant_dma)
  );

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    bus_d         = bus_q;
    bus_request_d = bus_request_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    cpu_ready_d   = 1'b0;
    dma_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_dma) begin
          bus_d         = dma_req;
          bus_request_d = 1'b1;
          starve_cnt_d  = '0;
          state_d       = GRANT_DMA;
        end else if (grant_cpu) begin
          bus_d         = cpu_req;
          bus_request_d = 1'b1;
          state_d       = GRANT_CPU;
          // Only CPU wins that actually held off a waiting DMA count toward starvation.
          if (!i_dma_request)               starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT)   starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
          starve_cnt_d = '0;
        end
      end
      GRANT_CPU: begin
        if (i_bus_ready) begin
          bus_request_d = 1'b0;
          cpu_rdata_d   = i_bus_rdata;
          cpu_ready_d   = 1'b1;
          state_d       = RELEASE_CPU;
        end
      end
      GRANT_DMA: begin
        if (i_bus_ready) begin
          bus_request_d = 1'b0;
          dma_rdata_d   = i_bus_rdata;
          dma_ready_d   = 1'b1;
          state_d       = RELEASE_DMA;
        end
      end
      // Wait for the master to drop its request so a stale one is never re-granted.
      RELEASE_CPU: if (!i_cpu_request) state_d = IDLE;
      RELEASE_DMA: if (!i_dma_request) state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    dma_stall_d = (state_d == GRANT_CPU) || (state_d == RELEASE_CPU) ||
                  (i_cpu_request && (starve_cnt_q < LIMIT) &&
                   (state_d != GRANT_DMA) && (state_d != RELEASE_DMA));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      bus_q         <= '0;
      bus_request_q <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      dma_ready_q   <= 1'b0;
      dma_stall_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      bus_q         <= bus_d;
      bus_request_q <= bus_request_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      cpu_ready_q   <= cpu_ready_d;
      dma_ready_q   <= dma_ready_d;
      dma_stall_q   <= dma_stall_d;
    end
  end

  assign o_bus_request = bus_request_q;
  assign o_bus_rw      = bus_q.rw;
  assign o_bus_address = bus_q.address;
  assign o_bus_wdata   = bus_q.wdata;
  assign o_cpu_rdata   = cpu_rdata_q;
  assign o_cpu_ready   = cpu_ready_q;
  assign o_dma_rdata   = dma_rdata_q;
  assign o_dma_ready   = dma_ready_q;
  assign o_dma_stall   = dma_stall_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter, run with STARVE_LIMIT=3.
module tb_bus_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cpu_request = 1'b0, i_cpu_rw = 1'b0;
  logic [31:0] i_cpu_address = '0, i_cpu_wdata = '0;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_ready;
  logic        i_dma_request = 1'b0, i_dma_rw = 1'b0;
  logic [31:0] i_dma_address = '0, i_dma_wdata = '0;
  logic [31:0] o_dma_rdata;
  logic        o_dma_ready, o_dma_stall;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 i_clock = ~i_clock;

  bus_arbiter #(
    .STARVE_LIMIT(3)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cpu_request(i_cpu_request), .i_cpu_rw(i_cpu_rw),
    .i_cpu_address(i_cpu_address), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata), .o_cpu_ready(o_cpu_ready),
    .i_dma_request(i_dma_request), .i_dma_rw(i_dma_rw),
    .i_dma_address(i_dma_address), .i_dma_wdata(i_dma_wdata),
    .o_dma_rdata(o_dma_rdata), .o_dma_ready(o_dma_ready), .o_dma_stall(o_dma_stall),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic slave_complete(input logic [31:0] rdata);
    i_bus_ready = 1'b1;
    i_bus_rdata = rdata;
    tick();
    i_bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #2;
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL reset_bus_request: got %b want 0", o_bus_request); end
    checks++; if (o_dma_stall !== 1'b0) begin failures++; $display("FAIL reset_dma_stall: got %b want 0", o_dma_stall); end
    checks++; if ({o_cpu_ready, o_dma_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", {o_cpu_ready, o_dma_ready}); end
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    i_cpu_request = 1'b1; i_cpu_rw = 1'b0; i_cpu_address = 32'h100;
    #1;
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL cpu_read_no_comb_path: got %b want 0", o_bus_request); end
    tick();
    checks++; if (o_bus_request !== 1'b1) begin failures++; $display("FAIL cpu_read_latency: got %b want 1", o_bus_request); end
    checks++; if (o_bus_address !== 32'h100 || o_bus_rw !== 1'b0) begin failures++; $display("FAIL cpu_read_addr: got %h/%b want 00000100/0", o_bus_address, o_bus_rw); end
    checks++; if (o_dma_stall !== 1'b1) begin failures++; $display("FAIL cpu_read_stall: got %b want 1", o_dma_stall); end
    tick(); tick();
    checks++; if (o_cpu_ready !== 1'b0 || o_bus_request !== 1'b1) begin failures++; $display("FAIL cpu_read_wait: got ready=%b req=%b want 0/1", o_cpu_ready, o_bus_request); end
    slave_complete(32'hDEADBEEF);
    checks++; if (o_cpu_ready !== 1'b1 || o_cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_read_done: got ready=%b rdata=%h want 1/deadbeef", o_cpu_ready, o_cpu_rdata); end
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL cpu_read_bus_drop: got %b want 0", o_bus_request); end
    i_cpu_request = 1'b0;
    tick();
    checks++; if (o_cpu_ready !== 1'b0 || o_cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_read_pulse: got ready=%b rdata=%h want 0/deadbeef", o_cpu_ready, o_cpu_rdata); end
    checks++; if (o_dma_ready !== 1'b0 || o_dma_rdata !== 32'h0) begin failures++; $display("FAIL cpu_read_dma_untouched: got ready=%b rdata=%h want 0/0", o_dma_ready, o_dma_rdata); end
  endtask

  task automatic test_simultaneous();
    i_cpu_request = 1'b1; i_cpu_rw = 1'b1; i_cpu_address = 32'h200; i_cpu_wdata = 32'hAAAA_0200;
    i_dma_request = 1'b1; i_dma_rw = 1'b1; i_dma_address = 32'h300; i_dma_wdata = 32'hBBBB_0300;
    tick();
    checks++; if (o_bus_address !== 32'h200 || o_bus_wdata !== 32'hAAAA_0200 || o_bus_rw !== 1'b1) begin failures++; $display("FAIL simul_cpu_first: got %h/%h/%b want 00000200/aaaa0200/1", o_bus_address, o_bus_wdata, o_bus_rw); end
    checks++; if (o_dma_stall !== 1'b1) begin failures++; $display("FAIL simul_stall_cpu: got %b want 1", o_dma_stall); end
    slave_complete(32'h0);
    i_cpu_request = 1'b0;
    tick();
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL simul_release: got %b want 0", o_bus_request); end
    tick();
    checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h300 || o_bus_wdata !== 32'hBBBB_0300) begin failures++; $display("FAIL simul_dma_second: got %b/%h/%h want 1/00000300/bbbb0300", o_bus_request, o_bus_address, o_bus_wdata); end
    checks++; if (o_dma_stall !== 1'b0) begin failures++; $display("FAIL simul_stall_dma: got %b want 0", o_dma_stall); end
    slave_complete(32'h0BAD_0300);
    checks++; if (o_dma_ready !== 1'b1 || o_dma_rdata !== 32'h0BAD_0300) begin failures++; $display("FAIL simul_dma_done: got %b/%h want 1/0bad0300", o_dma_ready, o_dma_rdata); end
    i_dma_request = 1'b0;
    tick();
  endtask

  // With LIMIT=3 and both masters always requesting, grants go C C C D C C C D.
  task automatic test_starvation();
    logic exp_dma;
    i_dma_request = 1'b1; i_dma_rw = 1'b0; i_dma_address = 32'h400;
    i_cpu_rw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_dma = ((k % 4) == 3);
      i_cpu_request = 1'b1;
      i_cpu_address = 32'h500 + 32'(k * 4);
      i_dma_request = 1'b1;
      tick();
      checks++;
      if (exp_dma && o_bus_address !== 32'h400) begin failures++; $display("FAIL starve_grant_%0d: got %h want 00000400", k, o_bus_address); end
      else if (!exp_dma && o_bus_address !== 32'h500 + 32'(k * 4)) begin failures++; $display("FAIL starve_grant_%0d: got %h want %h", k, o_bus_address, 32'h500 + 32'(k * 4)); end
      checks++; if (o_dma_stall !== !exp_dma) begin failures++; $display("FAIL starve_stall_%0d: got %b want %b", k, o_dma_stall, !exp_dma); end
      slave_complete(32'h1000 + 32'(k));
      if (exp_dma) i_dma_request = 1'b0;
      else         i_cpu_request = 1'b0;
      tick();
    end
    i_cpu_request = 1'b0;
    i_dma_request = 1'b0;
    tick();
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL starve_idle: got %b want 0", o_bus_request); end
  endtask

  task automatic test_held_request();
    int pulses = 0;
    i_cpu_request = 1'b1; i_cpu_rw = 1'b0; i_cpu_address = 32'h600;
    tick();
    slave_complete(32'h0000_1234);
    if (o_cpu_ready === 1'b1) pulses++;
    tick();
    if (o_cpu_ready === 1'b1) pulses++;
    checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL held_no_regrant_a: got %b want 0", o_bus_request); end
    i_cpu_request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_cpu_ready === 1'b1) pulses++;
      checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL held_no_regrant_%0d: got %b want 0", i, o_bus_request); end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL held_ready_pulses: got %0d want 1", pulses); end
    checks++; if (o_cpu_rdata !== 32'h0000_1234) begin failures++; $display("FAIL held_rdata: got %h want 00001234", o_cpu_rdata); end
  endtask

  task automatic test_reset_mid_grant();
    i_dma_request = 1'b1; i_dma_rw = 1'b1; i_dma_address = 32'h700; i_dma_wdata = 32'h55;
    tick();
    checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h700) begin failures++; $display("FAIL rst_mid_grant: got %b/%h want 1/00000700", o_bus_request, o_bus_address); end
    tick();
    #3;
    i_reset = 1'b1;
    #1;
    checks++; if ({o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata} !== 66'h0) begin failures++; $display("FAIL rst_mid_bus: got %b/%b/%h/%h want all 0", o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata); end
    checks++; if ({o_cpu_rdata, o_dma_rdata} !== 64'h0) begin failures++; $display("FAIL rst_mid_rdata: got %h/%h want 0/0", o_cpu_rdata, o_dma_rdata); end
    checks++; if ({o_cpu_ready, o_dma_ready, o_dma_stall} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags: got %b want 000", {o_cpu_ready, o_dma_ready, o_dma_stall}); end
    i_dma_request = 1'b0;
    #2;
    i_reset = 1'b0;
    i_cpu_request = 1'b1; i_cpu_rw = 1'b0; i_cpu_address = 32'h800;
    tick();
    checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h800) begin failures++; $display("FAIL rst_after_grant: got %b/%h want 1/00000800", o_bus_request, o_bus_address); end
    slave_complete(32'h0000_0800);
    checks++; if (o_cpu_ready !== 1'b1 || o_cpu_rdata !== 32'h0000_0800) begin failures++; $display("FAIL rst_after_done: got %b/%h want 1/00000800", o_cpu_ready, o_cpu_rdata); end
    i_cpu_request = 1'b0;
    tick();
  endtask

  task automatic test_dma_copy();
    i_dma_request = 1'b1; i_dma_rw = 1'b0; i_dma_address = 32'h1000;
    tick();
    checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h1000 || o_bus_rw !== 1'b0) begin failures++; $display("FAIL copy_read_grant: got %b/%h/%b want 1/00001000/0", o_bus_request, o_bus_address, o_bus_rw); end
    checks++; if (o_dma_stall !== 1'b0) begin failures++; $display("FAIL copy_stall_a: got %b want 0", o_dma_stall); end
    slave_complete(32'hCAFE_0001);
    checks++; if (o_dma_ready !== 1'b1 || o_dma_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL copy_read_done: got %b/%h want 1/cafe0001", o_dma_ready, o_dma_rdata); end
    i_dma_request = 1'b0;
    tick();
    checks++; if (o_dma_stall !== 1'b0 || o_bus_request !== 1'b0) begin failures++; $display("FAIL copy_gap: got stall=%b req=%b want 0/0", o_dma_stall, o_bus_request); end
    i_dma_request = 1'b1; i_dma_rw = 1'b1; i_dma_address = 32'h2000; i_dma_wdata = 32'hCAFE_0001;
    tick();
    checks++; if (o_bus_address !== 32'h2000 || o_bus_rw !== 1'b1 || o_bus_wdata !== 32'hCAFE_0001) begin failures++; $display("FAIL copy_write_grant: got %h/%b/%h want 00002000/1/cafe0001", o_bus_address, o_bus_rw, o_bus_wdata); end
    checks++; if (o_dma_stall !== 1'b0) begin failures++; $display("FAIL copy_stall_b: got %b want 0", o_dma_stall); end
    slave_complete(32'h0);
    checks++; if (o_dma_ready !== 1'b1 || o_dma_stall !== 1'b0) begin failures++; $display("FAIL copy_write_done: got ready=%b stall=%b want 1/0", o_dma_ready, o_dma_stall); end
    i_dma_request = 1'b0;
    tick();
    checks++; if (o_dma_ready !== 1'b0) begin failures++; $display("FAIL copy_pulse: got %b want 0", o_dma_ready); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_starvation();
    test_held_request();
    test_reset_mid_grant();
    test_dma_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
